// File: rtl/matb_fill_ctrl.sv
// Matrix-B fill controller: writes P*M+1 words into a BRAM on port A
// (random, constant-block, all-ones and terminating zero words), then serves
// round-robin reads from two requesters on port B until the next start.
module matb_fill_ctrl #(
    parameter int P   = 4,
    parameter int M   = 3,
    parameter int COL = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      ran,
    input  logic             ran_valid,
    output logic             ran_ready,
    input  logic [32*P-1:0]  col_vec,
    output logic             mem_we,
    output logic [7:0]       mem_waddr,
    output logic [31:0]      mem_wdata,
    input  logic [1:0]       rd_req,
    input  logic [7:0]       rd_addr0,
    input  logic [7:0]       rd_addr1,
    output logic             mem_re,
    output logic [7:0]       mem_raddr,
    output logic [1:0]       rd_grant,
    output logic [1:0]       rd_valid,
    output logic             busy,
    output logic             done
);

    // w is one bit wider than the address so that the post-fill index
    // (P*M+1) cannot wrap even when P*M+1 reaches 256.
    localparam logic [8:0] LAST_W = 9'(P * M);
    localparam logic [8:0] END_W  = 9'(P * M + 1);
    localparam logic [8:0] ONE_LO = 9'((M - 1) * P);
    localparam logic [8:0] COL_LO = 9'(COL * P);
    localparam logic [8:0] COL_HI = 9'(COL * P + P);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        SERVE
    } state_t;

    state_t      state, state_nxt;
    logic [8:0]  w, w_nxt;
    logic        rr, rr_nxt;
    logic [7:0]  col_idx;
    logic [31:0] word_const;
    logic        word_is_rand;
    logic        fill_active;
    logic        word_write;
    logic [31:0] wdata_nxt;

    // Classify the current word; earlier rules take priority over later ones.
    always_comb begin
        word_const   = '0;
        word_is_rand = 1'b0;
        col_idx      = w[7:0] - COL_LO[7:0];
        if (w == LAST_W) begin
            word_const = '0;
        end else if (w >= ONE_LO && w < LAST_W) begin
            word_const = 32'd1;
        end else if (w >= COL_LO && w < COL_HI) begin
            word_const = col_vec[{col_idx, 5'd0} +: 32];
        end else begin
            word_is_rand = 1'b1;
        end
    end

    assign fill_active = (state == FILL) && (w <= LAST_W);
    assign ran_ready   = fill_active && word_is_rand;
    assign word_write  = fill_active && (!word_is_rand || ran_valid);
    assign wdata_nxt   = word_is_rand ? ran : word_const;
    assign busy        = (state == FILL);
    assign done        = (state == SERVE);

    // Next-state and word-index logic. FILL lingers one cycle at END_W so
    // the final port-A write is presented before SERVE enables port B.
    always_comb begin
        state_nxt = state;
        w_nxt     = w;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = FILL;
                    w_nxt     = '0;
                end
            end
            FILL: begin
                if (word_write) begin
                    w_nxt = w + 9'd1;
                end else if (w == END_W) begin
                    state_nxt = SERVE;
                end
            end
            SERVE: begin
                if (start) begin
                    state_nxt = FILL;
                    w_nxt     = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Round-robin read arbiter; a start in SERVE suppresses that cycle's grant.
    always_comb begin
        rd_grant  = '0;
        rr_nxt    = rr;
        mem_raddr = '0;
        if (state == SERVE && !start) begin
            if (rd_req == 2'b11) begin
                rd_grant = rr ? 2'b10 : 2'b01;
            end else begin
                rd_grant = rd_req;
            end
        end
        if (rd_grant[0]) begin
            mem_raddr = rd_addr0;
            rr_nxt    = 1'b1;
        end else if (rd_grant[1]) begin
            mem_raddr = rd_addr1;
            rr_nxt    = 1'b0;
        end
        mem_re = |rd_grant;
    end

    // State, index, registered write port and read-valid pipeline.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            w         <= '0;
            rr        <= 1'b0;
            mem_we    <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= '0;
            rd_valid  <= '0;
        end else begin
            state    <= state_nxt;
            w        <= w_nxt;
            rr       <= rr_nxt;
            mem_we   <= word_write;
            rd_valid <= rd_grant;
            if (word_write) begin
                mem_waddr <= w[7:0];
                mem_wdata <= wdata_nxt;
            end
        end
    end

endmodule

// File: tb/tb_matb_fill_ctrl.sv
// Self-checking bench for matb_fill_ctrl: expected writes and read-valids are
// queued when stimulus is driven and compared when the DUT produces them.
module tb_matb_fill_ctrl;

    localparam int P   = 4;
    localparam int M   = 3;
    localparam int COL = 1;
    localparam int NW  = P * M + 1;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [31:0]     ran;
    logic            ran_valid;
    logic            ran_ready;
    logic [32*P-1:0] col_vec;
    logic            mem_we;
    logic [7:0]      mem_waddr;
    logic [31:0]     mem_wdata;
    logic [1:0]      rd_req;
    logic [7:0]      rd_addr0;
    logic [7:0]      rd_addr1;
    logic            mem_re;
    logic [7:0]      mem_raddr;
    logic [1:0]      rd_grant;
    logic [1:0]      rd_valid;
    logic            busy;
    logic            done;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] ran_val = 32'd100;
    logic        mrr = 1'b0;
    logic [39:0] wq[$];

    matb_fill_ctrl #(.P(P), .M(M), .COL(COL)) dut (
        .clk(clk), .reset(reset), .start(start),
        .ran(ran), .ran_valid(ran_valid), .ran_ready(ran_ready),
        .col_vec(col_vec),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .rd_req(rd_req), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
        .mem_re(mem_re), .mem_raddr(mem_raddr),
        .rd_grant(rd_grant), .rd_valid(rd_valid),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic exp_is_rand(input int w);
        return !((w == P * M) || (w >= (M - 1) * P && w < P * M) ||
                 (w >= COL * P && w < COL * P + P));
    endfunction

    function automatic logic [31:0] exp_const(input int w);
        if (w == P * M) return 32'd0;
        if (w >= (M - 1) * P) return 32'd1;
        return col_vec[32 * (w - COL * P) +: 32];
    endfunction

    // Start a fill (optionally stalling ran_valid at one word) and follow it to done.
    task automatic do_fill(input int stall_w, input int stall_n,
                           input logic [1:0] req, input logic [1:0] inflight);
        int          mw, stalled, nwr, gaps, cyc, last_wr;
        logic        rnd, fin;
        logic [39:0] e;
        logic [7:0]  exp_a;
        mw = 0; stalled = 0; nwr = 0; gaps = 0; cyc = 0; last_wr = -10; fin = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; rd_req = req; ran_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (rd_grant !== 2'b00 || mem_re !== 1'b0) begin
            errors++;
            $display("FAIL start_cycle_grant: rd_grant=%b mem_re=%b required 00/0", rd_grant, mem_re);
        end
        checks++;
        if (rd_valid !== inflight) begin
            errors++;
            $display("FAIL inflight_valid: rd_valid=%b required %b", rd_valid, inflight);
        end
        @(posedge clk); #1;
        start = 1'b0;
        while (!fin && cyc < 200) begin
            rnd = (mw <= P * M) && exp_is_rand(mw);
            if (rnd && mw == stall_w && stalled < stall_n) begin
                ran_valid = 1'b0; ran = 32'hDEAD_BEEF; stalled++;
            end else begin
                ran_valid = 1'b1; ran = ran_val;
            end
            if (mw <= P * M && (!rnd || ran_valid)) begin
                wq.push_back({8'(mw), rnd ? ran_val : exp_const(mw)});
                if (rnd) ran_val++;
                mw++;
            end
            @(negedge clk);
            checks++;
            if (ran_ready !== rnd) begin
                errors++;
                $display("FAIL ran_ready: w=%0d got %b required %b", mw, ran_ready, rnd);
            end
            if (mem_we === 1'b1) begin
                checks++;
                if (wq.size() == 0) begin
                    errors++;
                    $display("FAIL extra_write: addr=%0d data=%0d required no write", mem_waddr, mem_wdata);
                end else begin
                    e = wq.pop_front();
                    if ({mem_waddr, mem_wdata} !== e) begin
                        errors++;
                        $display("FAIL write: addr=%0d data=%0d required addr=%0d data=%0d",
                                 mem_waddr, mem_wdata, e[39:32], e[31:0]);
                    end
                end
                nwr++; last_wr = cyc;
            end else if (nwr > 0 && nwr < NW) begin
                gaps++;
            end
            if (done === 1'b1) begin
                fin = 1'b1;
                exp_a = req[0] ? rd_addr0 : (req[1] ? rd_addr1 : 8'd0);
                checks++;
                if (nwr != NW || last_wr != cyc - 1) begin
                    errors++;
                    $display("FAIL done_timing: writes=%0d last_write_cycle=%0d done_cycle=%0d required %0d writes, done one cycle after last",
                             nwr, last_wr, cyc, NW);
                end
                checks++;
                if (busy !== 1'b0 || rd_grant !== req || mem_raddr !== exp_a) begin
                    errors++;
                    $display("FAIL first_serve: busy=%b rd_grant=%b mem_raddr=%0d required 0/%b/%0d",
                             busy, rd_grant, mem_raddr, req, exp_a);
                end
                if (req != 2'b00) mrr = req[0];
            end else begin
                checks++;
                if (busy !== 1'b1 || done !== 1'b0 || rd_grant !== 2'b00 || mem_re !== 1'b0) begin
                    errors++;
                    $display("FAIL fill_state: busy=%b done=%b rd_grant=%b mem_re=%b required 1/0/00/0",
                             busy, done, rd_grant, mem_re);
                end
            end
            cyc++;
            if (!fin) begin
                @(posedge clk); #1;
            end
        end
        if (!fin) begin
            checks++; errors++;
            $display("FAIL fill_timeout: done not seen after %0d cycles", cyc);
        end
        checks++;
        if (gaps != stall_n || wq.size() != 0) begin
            errors++;
            $display("FAIL stall_gaps: gaps=%0d pending=%0d required %0d/0", gaps, wq.size(), stall_n);
        end
        ran_valid = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({mem_we, mem_re, ran_ready, busy, done, rd_grant, rd_valid} !== 9'd0 ||
            mem_waddr !== 8'd0 || mem_wdata !== 32'd0 || mem_raddr !== 8'd0) begin
            errors++;
            $display("FAIL reset_outputs: we=%b re=%b rdy=%b busy=%b done=%b gnt=%b vld=%b required all 0",
                     mem_we, mem_re, ran_ready, busy, done, rd_grant, rd_valid);
        end
        rd_req = 2'b11;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (rd_grant !== 2'b00 || busy !== 1'b0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: rd_grant=%b busy=%b mem_we=%b required 00/0/0", rd_grant, busy, mem_we);
        end
        rd_req = 2'b00;
        reset = 1'b0;
    endtask

    task automatic test_full_fill;
        do_fill(-1, 0, 2'b00, 2'b00);
    endtask

    task automatic test_arbitration;
        logic [1:0] vq[$];
        logic [1:0] g, ev;
        logic [7:0] ea;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            rd_req = (i < 4) ? 2'b11 : 2'b00;
            g = (i < 4) ? (mrr ? 2'b10 : 2'b01) : 2'b00;
            ea = g[1] ? 8'd9 : (g[0] ? 8'd5 : 8'd0);
            @(negedge clk);
            if (vq.size() > 0) begin
                ev = vq.pop_front();
                checks++;
                if (rd_valid !== ev) begin
                    errors++;
                    $display("FAIL arb_valid: cycle=%0d rd_valid=%b required %b", i, rd_valid, ev);
                end
            end
            checks++;
            if (rd_grant !== g || mem_re !== (g != 2'b00) || mem_raddr !== ea) begin
                errors++;
                $display("FAIL arb_grant: cycle=%0d rd_grant=%b mem_re=%b mem_raddr=%0d required %b/%b/%0d",
                         i, rd_grant, mem_re, mem_raddr, g, (g != 2'b00), ea);
            end
            vq.push_back(g);
            if (g != 2'b00) mrr = g[0];
        end
    endtask

    task automatic test_stall;
        do_fill(2, 3, 2'b01, 2'b00);
    endtask

    task automatic test_start_in_serve;
        @(posedge clk); #1;
        rd_req = 2'b10;
        @(negedge clk);
        checks++;
        if (rd_grant !== 2'b10 || mem_raddr !== 8'd9) begin
            errors++;
            $display("FAIL single_grant: rd_grant=%b mem_raddr=%0d required 10/9", rd_grant, mem_raddr);
        end
        mrr = 1'b0;
        do_fill(-1, 0, 2'b10, 2'b10);
    endtask

    task automatic test_reset_mid_fill;
        @(posedge clk); #1;
        start = 1'b1; rd_req = 2'b00;
        @(posedge clk); #1;
        start = 1'b0; ran_valid = 1'b1; ran = 32'd7;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (mem_we !== 1'b1 || mem_waddr !== 8'd5) begin
            errors++;
            $display("FAIL pre_abort: mem_we=%b mem_waddr=%0d required 1/5", mem_we, mem_waddr);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({mem_we, mem_re, ran_ready, busy, done, rd_grant, rd_valid} !== 9'd0 ||
            mem_waddr !== 8'd0 || mem_wdata !== 32'd0 || mem_raddr !== 8'd0) begin
            errors++;
            $display("FAIL async_reset: we=%b re=%b rdy=%b busy=%b done=%b addr=%0d required all 0",
                     mem_we, mem_re, ran_ready, busy, done, mem_waddr);
        end
        #1;
        reset = 1'b0; ran_valid = 1'b0;
        mrr = 1'b0;
        wq.delete();
        do_fill(-1, 0, 2'b00, 2'b00);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; ran = '0; ran_valid = 1'b0;
        rd_req = 2'b00; rd_addr0 = 8'd5; rd_addr1 = 8'd9;
        col_vec = {32'd4, 32'd3, 32'd2, 32'd1};
        test_reset;
        test_full_fill;
        test_arbitration;
        test_stall;
        test_start_in_serve;
        test_reset_mid_fill;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
